// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
//   - fetch_state_e : fetch FSM states
//   - fetch_entry_t : one queued {pc, instr} pair (64 bits)
//   - PC_STEP, NOP_INSTR, align_pc() helper
package if_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  // Bubble encoding (addi x0,x0,0) for consumers that need to inject a NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-align a PC by clearing bits [1:0].
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of {pc, instr} entries.
// Ports:
//   clk_i, rst_i (async, active low)
//   push_i/entry_i : write an entry (ignored when full)
//   pop_i          : drop the head (ignored when empty)
//   flush_i        : clear the FIFO; wins over push and pop
//   head_o         : head entry, all zero when empty
//   count_o, empty_o, full_o : occupancy
module if_fifo
  import if_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // Storage has no reset; empty_o masks stale contents on the head port.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding
// memory reads over req/ack, prefetch FIFO toward decode over valid/ready,
// and redirect handling that flushes queued and in-flight fetches.
// Ports:
//   clk_i, rst_i (async, active low), start_i (fetch enable)
//   mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i : instruction memory
//   redirect_i/redirect_pc_i                   : branch/jump restart
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decode side
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic          push, pop, fifo_empty, fifo_full;
  logic [CW-1:0] count, cnt_after;
  logic [31:0]   next_pc;
  fetch_entry_t  head, push_entry;

  assign pop        = instr_valid_o & instr_ready_i;
  assign next_pc    = addr_q + PC_STEP;
  // Occupancy after this cycle's push and pop; push only happens below DEPTH,
  // so this never overflows CW bits.
  assign cnt_after  = count + CW'(1) - CW'(pop);
  assign push_entry = '{pc: addr_q, instr: mem_rdata_i};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = align_pc(redirect_pc_i);
        end else if (start_i && !fifo_full) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fetch_pc_d = align_pc(redirect_pc_i);
          // Without ack the old request must still complete, so hold req/addr.
          if (mem_ack_i) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DISCARD;
          end
        end else if (mem_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = next_pc;
          if (start_i && (cnt_after < CW'(DEPTH))) begin
            addr_d = next_pc;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (redirect_i) fetch_pc_d = align_pc(redirect_pc_i);
        if (mem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  // Every redirect flushes; in DISCARD the FIFO is already empty.
  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
  logic        mem_ack_i = 1'b0, redirect_i = 1'b0, instr_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0, redirect_pc_i = '0;
  logic        mem_req_o, instr_valid_o;
  logic [31:0] mem_addr_o, instr_o, instr_pc_o;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  // Stimulus knobs; k_ack: 0 never, 1 whenever requesting, 2 random
  bit          k_start, k_ready, k_redir;
  int          k_ack;
  logic [31:0] k_rpc;

  // Reference model: mode 0 idle, 1 requesting, 2 draining a dead request
  int          m_mode;
  bit          m_req;
  logic [31:0] m_pc, m_addr;
  logic [63:0] mq[$];   // {pc, instr}

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_req = 1'b0; m_pc = RESET_PC; m_addr = RESET_PC; mq.delete();
  endtask

  task automatic m_step();
    int  sz0;
    bit  pop;
    sz0 = mq.size();
    pop = (sz0 != 0) && instr_ready_i;
    if (redirect_i) begin
      mq.delete();
      m_pc = redirect_pc_i & ~32'h3;
      if (m_mode == 1)                   m_mode = mem_ack_i ? 0 : 2;
      else if (m_mode == 2 && mem_ack_i) m_mode = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_mode == 0) begin
        if (start_i && sz0 < DEPTH) begin m_mode = 1; m_addr = m_pc; end
      end else if (m_mode == 1) begin
        if (mem_ack_i) begin
          mq.push_back({m_addr, mem_rdata_i});
          m_pc = m_addr + 32'd4;
          if (start_i && mq.size() < DEPTH) m_addr = m_pc;
          else m_mode = 0;
        end
      end else if (mem_ack_i) begin
        m_mode = 0;
      end
    end
    m_req = (m_mode != 0);
  endtask

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic step();
    start_i       = k_start;
    instr_ready_i = k_ready;
    redirect_i    = k_redir;
    redirect_pc_i = k_rpc;
    mem_ack_i     = m_req && (k_ack == 1 || (k_ack == 2 && ($urandom % 2) == 1));
    mem_rdata_i   = m_addr ^ XMASK;
    @(posedge clk_i);
    if (rst_i) m_step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    k_start = 0; k_ready = 0; k_redir = 0; k_ack = 0; k_rpc = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_reset();
    step();
    step();
    rst_i = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (chk_en && rst_i) begin
      chk("req",   {31'd0, mem_req_o},     {31'd0, m_req});
      chk("addr",  mem_addr_o,             m_addr);
      chk("valid", {31'd0, instr_valid_o}, {31'd0, mq.size() != 0});
      chk("instr", instr_o,    mq.size() != 0 ? mq[0][31:0]  : 32'h0);
      chk("pc",    instr_pc_o, mq.size() != 0 ? mq[0][63:32] : 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset values while reset is held
    do_reset();
    chk_en = 1'b1;
    rst_i = 1'b0;
    #1;
    chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr",  mem_addr_o, RESET_PC);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc",    instr_pc_o, 32'd0);

    // 1: streaming fetch, ack every cycle, decode always ready
    do_reset();
    k_start = 1; k_ready = 1; k_ack = 1;
    n = 0;
    while (!instr_valid_o && n < 10) begin step(); n++; end
    chk("s1_wait", {31'd0, instr_valid_o}, 32'd1);
    chk("s1_pc0", instr_pc_o, 32'h0);
    chk("s1_in0", instr_o, 32'hA5A5_0000);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("s1_gap", {31'd0, instr_valid_o}, 32'd1);
      chk("s1_pcN", instr_pc_o, 32'(i * 4));
      chk("s1_inN", instr_o, 32'(i * 4) ^ XMASK);
    end

    // 2: decode stalled -> FIFO fills to DEPTH, then one pop frees one fetch
    do_reset();
    k_start = 1; k_ready = 0; k_ack = 1;
    repeat (8) step();
    chk("s2_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("s2_count", mq.size(), 32'd4);
    chk("s2_head", instr_pc_o, 32'h0);
    k_ready = 1; step();
    k_ready = 0; step();
    chk("s2_req_on", {31'd0, mem_req_o}, 32'd1);
    chk("s2_addr", mem_addr_o, 32'h10);

    // 3: redirect while 0x8 pending, ack arrives 3 cycles later
    do_reset();
    k_start = 1; k_ready = 1; k_ack = 1;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h8) && n < 20) begin step(); n++; end
    chk("s3_wait8", mem_addr_o, 32'h8);
    k_ack = 0; k_redir = 1; k_rpc = 32'h100; step();
    k_redir = 0;
    chk("s3_empty", {31'd0, instr_valid_o}, 32'd0);
    chk("s3_hold", mem_addr_o, 32'h8);
    step(); step();
    k_ack = 1;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h100) && n < 10) begin step(); n++; end
    chk("s3_addr", mem_addr_o, 32'h100);
    n = 0;
    while (!instr_valid_o && n < 10) begin step(); n++; end
    chk("s3_first", instr_pc_o, 32'h100);

    // 4: redirect coincident with ack of 0x4 -> no DISCARD cycle
    do_reset();
    k_start = 1; k_ready = 1; k_ack = 1;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h4) && n < 20) begin step(); n++; end
    k_redir = 1; k_rpc = 32'h200; step();
    k_redir = 0;
    chk("s4_idle", {31'd0, mem_req_o}, 32'd0);
    chk("s4_flush", {31'd0, instr_valid_o}, 32'd0);
    step();
    chk("s4_req", {31'd0, mem_req_o}, 32'd1);
    chk("s4_addr", mem_addr_o, 32'h200);

    // 5: async reset mid-request with two entries queued
    do_reset();
    k_start = 1; k_ready = 0; k_ack = 1;
    n = 0;
    while (!(mq.size() == 2 && mem_req_o) && n < 20) begin step(); n++; end
    chk("s5_two", {31'd0, instr_valid_o}, 32'd1);
    #2 rst_i = 1'b0;
    m_reset();
    #1;
    chk("s5_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("s5_instr", instr_o, 32'd0);
    chk("s5_pc", instr_pc_o, 32'd0);
    chk("s5_req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    n = 0;
    while (!mem_req_o && n < 10) begin step(); n++; end
    chk("s5_restart", mem_addr_o, RESET_PC);

    // 6: wrap at top of address space; push+pop at count 2
    do_reset();
    k_start = 1; k_ready = 1; k_ack = 1; k_redir = 1; k_rpc = 32'hFFFF_FFFF;
    step();
    k_redir = 0;
    n = 0;
    while (!instr_valid_o && n < 10) begin step(); n++; end
    chk("s6_pc_top", instr_pc_o, 32'hFFFF_FFFC);
    chk("s6_in_top", instr_o, 32'h5A5A_FFFC);
    step();
    chk("s6_pc_wrap", instr_pc_o, 32'h0);
    chk("s6_in_wrap", instr_o, 32'hA5A5_0000);
    k_ready = 0;
    n = 0;
    while (!(mq.size() == 2 && mem_req_o) && n < 20) begin step(); n++; end
    k_ready = 1; step();
    chk("s6_model_cnt", mq.size(), 32'd2);
    k_ack = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid_o) n++;
      step();
    end
    chk("s6_drain", n, 32'd2);

    // Random traffic with occasional redirects and start toggles
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      k_start = ($urandom % 8) != 0;
      k_ready = ($urandom % 3) != 0;
      k_ack   = 2;
      k_redir = ($urandom % 16) == 0;
      k_rpc   = $urandom;
      step();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the CPU's decode/register stage.
- Generates sequential fetch PCs and issues single-outstanding read requests to instruction memory over a req/ack handshake.
- Buffers the returned words in a small prefetch FIFO and presents {instruction, PC} to the decode stage over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the queue and discards any in-flight response.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  fetch enable; while low, no new memory requests are issued.
- mem_req_o  output  1  instruction-memory read request.
- mem_addr_o  output  32  request address; word aligned.
- mem_ack_i  input  1  request accepted; mem_rdata_i is valid in this same cycle.
- mem_rdata_i  input  32  instruction word returned by memory.
- redirect_i  input  1  flush the queue and restart fetch at redirect_pc_i.
- redirect_pc_i  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- instr_valid_o  output  1  queue head is valid.
- instr_o  output  32  instruction at queue head.
- instr_pc_o  output  32  PC of the instruction at queue head.
- instr_ready_i  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE, fetch_pc=RESET_PC, FIFO count=0.
  - mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - A reset asserted mid-transaction abandons the transaction; the late ack is ignored because mem_req_o=0.
- FSM states: IDLE, REQ, DISCARD.
- IDLE -> REQ when start_i=1 and count<DEPTH. On entry, mem_addr_o=fetch_pc.
- In REQ:
  - mem_req_o=1; mem_addr_o is held stable until ack.
  - On mem_ack_i: push {mem_rdata_i, mem_addr_o} and set fetch_pc=mem_addr_o+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0).
  - Back-to-back requests: if start_i=1 and count after the push is < DEPTH, stay in REQ with the new address; otherwise go to IDLE.
- Only one request is outstanding at a time. A request is issued only if count<DEPTH, so a push never hits a full FIFO.
- Push and pop in the same cycle: count is unchanged; the FIFO remains FIFO ordered.
- Redirect in IDLE:
  - FIFO cleared at the next edge; fetch_pc=redirect_pc_i.
  - Fetch resumes the next cycle if start_i=1.
- Redirect in REQ without ack that cycle: FIFO cleared, fetch_pc=redirect_pc_i, go to DISCARD. mem_req_o and mem_addr_o stay unchanged (the old request must complete).
- Redirect in REQ with ack in the same cycle: the returned word is dropped, FIFO cleared, fetch_pc=redirect_pc_i, go to IDLE.
- DISCARD:
  - mem_req_o=1 with the old address until ack; the data is dropped.
  - Then go to IDLE. fetch_pc already holds the redirect target.
  - A further redirect in DISCARD only updates fetch_pc.
- Output side:
  - instr_valid_o = (count!=0). instr_o and instr_pc_o show the head entry; they are 0 when empty.
  - A pop occurs when instr_valid_o & instr_ready_i.
  - A pop in a redirect cycle is accepted, but the flush dominates: count=0 after the edge.
- start_i falling: an outstanding request still completes and is pushed. No further requests are issued. Queued entries remain poppable.
- Latency:
  - Request asserted 1 cycle after IDLE with start_i=1.
  - Pushed word visible on instr_valid_o 1 cycle after ack.

Decomposition:
- Shared package (if_pkg):
  - FSM state enum {IDLE, REQ, DISCARD}.
  - PC_STEP=32'd4.
  - Instruction width 32.
  - NOP encoding 32'h0000_0013, for consumers that need a bubble.
- One sub-module, if_fifo:
  - Synchronous DEPTH-entry FIFO of 64-bit {pc, instr}.
  - push/pop/flush inputs; count, empty and full outputs.
  - Same clk_i/rst_i convention; flush has priority over push.

Test Plan:
- Reset then start_i=1, memory acks every cycle with rdata=addr^32'hA5A5_0000, ready=1 -> requests at 0x0, 0x4, 0x8...; decode sees pc 0x0 instr 0xA5A5_0000 first, in order, no gaps after the first word.
- ready=0, DEPTH=4, acks immediate -> exactly 4 pushes (0x0-0xC), mem_req_o=0 afterwards; one pop -> one new request at 0x10.
- Redirect to 0x100 while a request at 0x8 is pending, ack delayed 3 cycles -> 0x8 data never appears, queue empty, next request at 0x100, first output pc 0x100.
- Redirect to 0x200 in the same cycle as ack of 0x4 -> 0x4 dropped, next request 0x200 with no DISCARD cycle.
- rst_i pulsed low mid-REQ with 2 entries queued -> outputs zero immediately (async), first request after release is RESET_PC.
- Redirect to 0xFFFF_FFFC -> next fetches 0xFFFF_FFFC then 0x0000_0000; simultaneous push and pop at count=2 leaves count=2.
